// File: rtl/push_encoder_debounced_if.sv
// Board-side bundle for the debounced push-button encoder: raw pins and
// quasi-static controls in, LED lanes / live code / press pulse out.
interface push_encoder_debounced_if #(
  parameter int unsigned N_BUTTONS = 8,
  parameter int unsigned ENC_W     = $clog2(N_BUTTONS + 1)
);
  logic [N_BUTTONS-1:0] buttons;     // raw, asynchronous, active-low
  logic                 switch;      // 1 = low lane, 0 = high lane
  logic                 latch_mode;  // 1 = show held code, 0 = live code
  logic                 clear;       // synchronous clear of held code
  logic [2*ENC_W-1:0]   leds;
  logic [ENC_W-1:0]     code;
  logic                 press_pulse;

  // Board / stimulus side
  modport master (
    output buttons, switch, latch_mode, clear,
    input  leds, code, press_pulse
  );

  // Encoder side
  modport slave (
    input  buttons, switch, latch_mode, clear,
    output leds, code, press_pulse
  );
endinterface

// File: rtl/push_encoder_debounced.sv
// Debounced, priority-encoded push-button front end. Each active-low button
// is synchronised (2 flops), debounced by its own stability counter, then the
// highest pressed index is encoded as index+1 (0 = none). The code (live or
// last-press held) is driven onto one of two LED lanes.
module push_encoder_debounced #(
  parameter int unsigned N_BUTTONS       = 8,
  parameter int unsigned ENC_W           = $clog2(N_BUTTONS + 1),
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  push_encoder_debounced_if.slave bus
);

  logic [N_BUTTONS-1:0]             s1_q, s2_q;
  logic [N_BUTTONS-1:0]             db_q, db_d, db_prev_q;
  logic [N_BUTTONS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [ENC_W-1:0]                 enc;
  logic [ENC_W-1:0]                 code_q;
  logic [ENC_W-1:0]                 held_q, held_d;
  logic [ENC_W-1:0]                 disp;
  logic [2*ENC_W-1:0]               leds_q, leds_d;
  logic                             press_evt;
  logic                             pulse_q;

  // Two-flop synchroniser per button; released (1) out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= bus.buttons;
      s2_q <= s1_q;
    end
  end

  // Per-button stability counter: accept s2 after DEBOUNCE_CYCLES differing cycles
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced state, its one-cycle history, and the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= '1;
      db_prev_q <= '1;
      cnt_q     <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  // Highest pressed index wins: later loop iterations override earlier ones
  always_comb begin
    enc = '0;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      if (!db_q[i]) begin
        enc = ENC_W'(i + 1);
      end
    end
  end

  // Press event, held-code update (press beats clear), lane steering
  always_comb begin
    press_evt = |(db_prev_q & ~db_q);
    held_d    = held_q;
    if (press_evt) begin
      held_d = enc;
    end else if (bus.clear) begin
      held_d = '0;
    end
    disp   = bus.latch_mode ? held_q : code_q;
    leds_d = bus.switch ? {{ENC_W{1'b0}}, disp} : {disp, {ENC_W{1'b0}}};
  end

  // Registered outputs and held code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      held_q  <= '0;
      leds_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      code_q  <= enc;
      held_q  <= held_d;
      leds_q  <= leds_d;
      pulse_q <= press_evt;
    end
  end

  assign bus.code        = code_q;
  assign bus.leds        = leds_q;
  assign bus.press_pulse = pulse_q;

endmodule

// File: tb/tb_push_encoder_debounced.sv
// Directed bench for push_encoder_debounced with N_BUTTONS = 8, DEBOUNCE_CYCLES = 4.
// A clean level change reaches code on the 7th rising edge after it is applied.
module tb_push_encoder_debounced;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  push_encoder_debounced_if #(.N_BUTTONS(8), .ENC_W(4)) bus ();

  push_encoder_debounced #(
    .N_BUTTONS      (8),
    .ENC_W          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.buttons = 8'hFF; bus.switch = 1'b1; bus.latch_mode = 1'b0; bus.clear = 1'b0;
    tick(); tick();
    checks++;
    if (bus.leds !== 8'h00 || bus.code !== 4'h0 || bus.press_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: leds=%h code=%h pulse=%b required 00/0/0", bus.leds, bus.code, bus.press_pulse);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.press_pulse !== 1'b0) begin
        errors++;
        $display("FAIL idle_pulse: cycle %0d pulse=%b required 0", i, bus.press_pulse);
      end
    end
    checks++;
    if (bus.leds !== 8'h00 || bus.code !== 4'h0) begin
      errors++;
      $display("FAIL idle_outputs: leds=%h code=%h required 00/0", bus.leds, bus.code);
    end
  endtask

  task automatic test_press_latency();
    bus.switch = 1'b1;
    bus.buttons = 8'hDF;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (bus.code !== ((e == 7) ? 4'd6 : 4'd0) || bus.press_pulse !== (e == 7)) begin
        errors++;
        $display("FAIL press_latency: edge %0d code=%0d pulse=%b required %0d/%b",
                 e, bus.code, bus.press_pulse, (e == 7) ? 6 : 0, (e == 7));
      end
    end
    tick();
    checks++;
    if (bus.leds !== 8'h06 || bus.press_pulse !== 1'b0) begin
      errors++;
      $display("FAIL press_leds_low: leds=%h pulse=%b required 06/0", bus.leds, bus.press_pulse);
    end
    bus.switch = 1'b0;
    tick();
    checks++;
    if (bus.leds !== 8'h60) begin
      errors++;
      $display("FAIL lane_high: leds=%h required 60", bus.leds);
    end
    bus.buttons = 8'hFF;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (bus.press_pulse !== 1'b0) begin
        errors++;
        $display("FAIL release_pulse: edge %0d pulse=%b required 0", e, bus.press_pulse);
      end
    end
    checks++;
    if (bus.code !== 4'd0) begin
      errors++;
      $display("FAIL release_code: code=%0d required 0", bus.code);
    end
    bus.switch = 1'b1;
    tick();
  endtask

  task automatic test_glitch();
    bus.buttons = 8'hF7;
    tick(); tick(); tick();
    bus.buttons = 8'hFF;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (bus.code !== 4'd0 || bus.press_pulse !== 1'b0) begin
        errors++;
        $display("FAIL glitch_reject: cycle %0d code=%0d pulse=%b required 0/0", e, bus.code, bus.press_pulse);
      end
    end
    bus.buttons = 8'hF7;
    for (int e = 0; e < 6; e++) tick();
    checks++;
    if (bus.code !== 4'd0) begin
      errors++;
      $display("FAIL glitch_early: code=%0d required 0", bus.code);
    end
    tick();
    checks++;
    if (bus.code !== 4'd4 || bus.press_pulse !== 1'b1) begin
      errors++;
      $display("FAIL glitch_accept: code=%0d pulse=%b required 4/1", bus.code, bus.press_pulse);
    end
    bus.buttons = 8'hFF;
    for (int e = 0; e < 8; e++) tick();
  endtask

  task automatic test_multi();
    int pulses;
    bus.buttons = 8'h7E;
    pulses = 0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (bus.press_pulse === 1'b1) pulses++;
    end
    checks++;
    if (bus.code !== 4'd8 || pulses != 1) begin
      errors++;
      $display("FAIL multi_press: code=%0d pulses=%0d required 8/1", bus.code, pulses);
    end
    bus.buttons = 8'hFE;
    pulses = 0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (bus.press_pulse === 1'b1) pulses++;
    end
    checks++;
    if (bus.code !== 4'd1 || pulses != 0) begin
      errors++;
      $display("FAIL partial_release: code=%0d pulses=%0d required 1/0", bus.code, pulses);
    end
    bus.buttons = 8'hFF;
    for (int e = 0; e < 8; e++) tick();
  endtask

  task automatic test_latch();
    bus.latch_mode = 1'b1;
    bus.switch = 1'b1;
    tick();
    checks++;
    if (bus.leds !== 8'h08) begin
      errors++;
      $display("FAIL held_after_release: leds=%h required 08", bus.leds);
    end
    bus.buttons = 8'hFB;
    for (int e = 0; e < 8; e++) tick();
    checks++;
    if (bus.leds !== 8'h03) begin
      errors++;
      $display("FAIL latch_press: leds=%h required 03", bus.leds);
    end
    bus.buttons = 8'hFF;
    for (int e = 0; e < 8; e++) tick();
    checks++;
    if (bus.leds !== 8'h03 || bus.code !== 4'd0) begin
      errors++;
      $display("FAIL latch_release: leds=%h code=%0d required 03/0", bus.leds, bus.code);
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
    checks++;
    if (bus.leds !== 8'h00) begin
      errors++;
      $display("FAIL latch_clear: leds=%h required 00", bus.leds);
    end
    bus.buttons = 8'hEF;
    for (int e = 0; e < 6; e++) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
    checks++;
    if (bus.leds !== 8'h05) begin
      errors++;
      $display("FAIL press_beats_clear: leds=%h required 05", bus.leds);
    end
    tick();
    checks++;
    if (bus.leds !== 8'h05) begin
      errors++;
      $display("FAIL press_beats_clear_hold: leds=%h required 05", bus.leds);
    end
    bus.buttons = 8'hFF;
    for (int e = 0; e < 8; e++) tick();
    bus.latch_mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.switch = 1'b1;
    bus.buttons = 8'hDF;
    for (int e = 0; e < 8; e++) tick();
    checks++;
    if (bus.code !== 4'd6 || bus.leds !== 8'h06) begin
      errors++;
      $display("FAIL pre_reset: code=%0d leds=%h required 6/06", bus.code, bus.leds);
    end
    bus.buttons = 8'hDE;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.code !== 4'd0 || bus.leds !== 8'h00 || bus.press_pulse !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: code=%0d leds=%h pulse=%b required 0/00/0", bus.code, bus.leds, bus.press_pulse);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (bus.code !== ((e == 7) ? 4'd6 : 4'd0) || bus.press_pulse !== (e == 7)) begin
        errors++;
        $display("FAIL reset_recovery: edge %0d code=%0d pulse=%b required %0d/%b",
                 e, bus.code, bus.press_pulse, (e == 7) ? 6 : 0, (e == 7));
      end
    end
    tick();
    checks++;
    if (bus.leds !== 8'h06) begin
      errors++;
      $display("FAIL reset_recovery_leds: leds=%h required 06", bus.leds);
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_multi();
    test_latch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
